// File: rtl/mac_rx_gather_pkg.sv
// Shared word-format definitions for the MAC receive gather and transmit gearbox.
package mac_rx_gather_pkg;

    localparam int unsigned BEAT_W         = 64;
    localparam int unsigned BEATS_PER_WORD = 4;
    localparam int unsigned PAYLOAD_W      = BEAT_W * BEATS_PER_WORD;
    localparam int unsigned WORD_W         = 267;

    // Field positions inside a gathered packet word
    localparam int unsigned CNT_LSB = 256;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SOP_BIT = 261;
    localparam int unsigned EOP_BIT = 262;
    localparam int unsigned ERR_BIT = 263;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } rx_state_t;

    // Valid bytes minus one: 6-bit arithmetic, truncated to the 5-bit field
    function automatic logic [CNT_W-1:0] byte_count(input logic [2:0] beats,
                                                    input logic [2:0] empty);
        logic [5:0] total;
        total = {beats, 3'b000} - {3'b000, empty} - 6'd1;
        return total[CNT_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input logic [PAYLOAD_W-1:0] payload,
                                                    input logic [CNT_W-1:0]     cnt,
                                                    input logic                 sop,
                                                    input logic                 eop,
                                                    input logic                 err);
        logic [WORD_W-1:0] word;
        word                           = '0;
        word[PAYLOAD_W-1:0]            = payload;
        word[CNT_LSB +: CNT_W]         = cnt;
        word[SOP_BIT]                  = sop;
        word[EOP_BIT]                  = eop;
        word[ERR_BIT]                  = err;
        return word;
    endfunction

endpackage

// File: rtl/mac_rx_gather.sv
// Gathers 64-bit MAC receive beats into 4-beat packet words with sop/eop/error
// flags and a byte count, held in a single output register for the packet FIFO.
module mac_rx_gather (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  rx_data,
    input  logic         rx_valid,
    input  logic         rx_sop,
    input  logic         rx_eop,
    input  logic [2:0]   rx_empty,
    input  logic         rx_error,
    output logic         rx_ready,
    input  logic         ddpPktFull,
    output logic         ddpPktPush,
    output logic [266:0] ddpPktDataIn,
    output logic [15:0]  rxDropCnt
);
    import mac_rx_gather_pkg::*;

    rx_state_t            state, state_nx;
    logic [1:0]           idx, idx_nx;
    logic [PAYLOAD_W-1:0] acc_data, acc_data_nx, lane_data;
    logic                 acc_err, acc_err_nx;
    logic                 acc_sop, acc_sop_nx;
    logic                 out_valid;
    logic [WORD_W-1:0]    out_word, emit_word;
    logic                 emit, drop, accept, push;
    logic [15:0]          drop_cnt;

    assign rx_ready     = ~out_valid | ~ddpPktFull;
    assign push         = out_valid & ~ddpPktFull;
    assign accept       = rx_valid & rx_ready;
    assign ddpPktPush   = push;
    assign ddpPktDataIn = out_word;
    assign rxDropCnt    = drop_cnt;

    // Next-state, accumulator update and word emission decode
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        acc_data_nx = acc_data;
        acc_err_nx  = acc_err;
        acc_sop_nx  = acc_sop;
        lane_data   = acc_data;
        emit        = 1'b0;
        emit_word   = '0;
        drop        = 1'b0;

        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (rx_sop) begin
                        lane_data = {{(PAYLOAD_W-BEAT_W){1'b0}}, rx_data};
                        if (rx_eop) begin
                            emit      = 1'b1;
                            emit_word = pack_word(lane_data, byte_count(3'd1, rx_empty),
                                                  1'b1, 1'b1, rx_error);
                        end else begin
                            state_nx    = BODY;
                            idx_nx      = 2'd1;
                            acc_data_nx = lane_data;
                            acc_err_nx  = rx_error;
                            acc_sop_nx  = 1'b1;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
                BODY: begin
                    if (rx_sop) begin
                        // Unexpected sop: close the partial word as a bad packet
                        emit        = 1'b1;
                        emit_word   = pack_word(acc_data, byte_count({1'b0, idx}, 3'd0),
                                                acc_sop, 1'b1, 1'b1);
                        drop        = 1'b1;
                        state_nx    = IDLE;
                        idx_nx      = '0;
                        acc_data_nx = '0;
                        acc_err_nx  = 1'b0;
                        acc_sop_nx  = 1'b0;
                    end else begin
                        for (int unsigned k = 0; k < BEATS_PER_WORD; k++) begin
                            if (idx == k[1:0])
                                lane_data[k*BEAT_W +: BEAT_W] = rx_data;
                        end
                        if (idx == 2'd3 || rx_eop) begin
                            emit        = 1'b1;
                            emit_word   = pack_word(lane_data,
                                                    byte_count({1'b0, idx} + 3'd1,
                                                               rx_eop ? rx_empty : 3'd0),
                                                    acc_sop, rx_eop, acc_err | rx_error);
                            idx_nx      = '0;
                            acc_data_nx = '0;
                            acc_err_nx  = 1'b0;
                            acc_sop_nx  = 1'b0;
                            if (rx_eop)
                                state_nx = IDLE;
                        end else begin
                            idx_nx      = idx + 2'd1;
                            acc_data_nx = lane_data;
                            acc_err_nx  = acc_err | rx_error;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, accumulator, output holding register and drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc_data  <= '0;
            acc_err   <= 1'b0;
            acc_sop   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            drop_cnt  <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            acc_data <= acc_data_nx;
            acc_err  <= acc_err_nx;
            acc_sop  <= acc_sop_nx;
            if (emit) begin
                out_valid <= 1'b1;
                out_word  <= emit_word;
            end else if (push) begin
                out_valid <= 1'b0;
            end
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mac_rx_gather.sv
// Self-checking bench for mac_rx_gather: queue-based packet model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mac_rx_gather;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  rx_data;
    logic         rx_valid;
    logic         rx_sop;
    logic         rx_eop;
    logic [2:0]   rx_empty;
    logic         rx_error;
    logic         rx_ready;
    logic         ddpPktFull;
    logic         ddpPktPush;
    logic [266:0] ddpPktDataIn;
    logic [15:0]  rxDropCnt;

    always #5 clock = ~clock;

    mac_rx_gather dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sop       (rx_sop),
        .rx_eop       (rx_eop),
        .rx_empty     (rx_empty),
        .rx_error     (rx_error),
        .rx_ready     (rx_ready),
        .ddpPktFull   (ddpPktFull),
        .ddpPktPush   (ddpPktPush),
        .ddpPktDataIn (ddpPktDataIn),
        .rxDropCnt    (rxDropCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [266:0] act, input logic [266:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]  m_beats[$];
    logic         m_in_pkt = 1'b0;
    logic         m_err    = 1'b0;
    logic         m_sop    = 1'b0;
    logic         m_ov     = 1'b0;
    logic [266:0] m_word   = '0;
    int           m_drop   = 0;
    logic         armed    = 1'b0;
    logic [266:0] log_q[$];

    function automatic logic [266:0] build(input logic eopf, input logic errf, input int emp);
        logic [255:0] pl;
        int           c;
        pl = '0;
        for (int i = 0; i < m_beats.size(); i++)
            pl[i*64 +: 64] = m_beats[i];
        c = (int'(m_beats.size()) * 8 - emp - 1) & 31;
        return {3'b000, errf, eopf, m_sop, c[4:0], pl};
    endfunction

    task automatic clear_word();
        m_beats.delete();
        m_err = 1'b0;
        m_sop = 1'b0;
    endtask

    task automatic drop_inc();
        if (m_drop < 16'hFFFF) m_drop++;
    endtask

    initial begin : compare_proc
        logic         exp_ready, exp_push, em;
        logic [266:0] nw;
        forever begin
            @(negedge clock);
            exp_ready = !m_ov || !ddpPktFull;
            exp_push  = m_ov && !ddpPktFull;
            if (armed) begin
                chk("rx_ready", rx_ready, exp_ready);
                chk("push", ddpPktPush, exp_push);
                chk("drop_cnt", rxDropCnt, m_drop);
                if (m_ov) chk("held_word", ddpPktDataIn, m_word);
            end
            if (ddpPktPush === 1'b1) log_q.push_back(ddpPktDataIn);
            if (reset) begin
                clear_word();
                m_in_pkt = 1'b0;
                m_ov     = 1'b0;
                m_word   = '0;
                m_drop   = 0;
                armed    = 1'b1;
            end else begin
                em = 1'b0;
                nw = '0;
                if (rx_valid && exp_ready) begin
                    if (!m_in_pkt) begin
                        if (rx_sop) begin
                            m_beats = {rx_data};
                            m_err   = rx_error;
                            m_sop   = 1'b1;
                            if (rx_eop) begin
                                nw = build(1'b1, m_err, int'(rx_empty));
                                em = 1'b1;
                                clear_word();
                            end else begin
                                m_in_pkt = 1'b1;
                            end
                        end else begin
                            drop_inc();
                        end
                    end else if (rx_sop) begin
                        nw = build(1'b1, 1'b1, 0);
                        em = 1'b1;
                        clear_word();
                        m_in_pkt = 1'b0;
                        drop_inc();
                    end else begin
                        m_beats.push_back(rx_data);
                        m_err = m_err | rx_error;
                        if (m_beats.size() == 4 || rx_eop) begin
                            nw = build(rx_eop, m_err, rx_eop ? int'(rx_empty) : 0);
                            em = 1'b1;
                            clear_word();
                            if (rx_eop) m_in_pkt = 1'b0;
                        end
                    end
                end
                if (em) begin
                    m_ov   = 1'b1;
                    m_word = nw;
                end else if (exp_push) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [63:0] d, input logic s, input logic e,
                        input logic [2:0] emp, input logic er);
        int waited;
        waited   = 0;
        rx_data  = d;
        rx_sop   = s;
        rx_eop   = e;
        rx_empty = emp;
        rx_error = er;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && waited < 100) begin
            waited++;
            @(negedge clock);
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got rx_ready=0 expected acceptance within 100 cycles");
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        rx_error = 1'b0;
    endtask

    function automatic logic [266:0] logged(input int i);
        if (i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        logic [266:0] w;
        logic [63:0]  dz;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rx_empty = '0; rx_error = 1'b0; ddpPktFull = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", rx_ready, 1);
        chk("rst_push", ddpPktPush, 0);
        chk("rst_data", ddpPktDataIn, 0);
        chk("rst_drop", rxDropCnt, 0);
        tick();

        // 4-beat packet
        log_q.delete();
        for (int i = 0; i < 4; i++) send(pat(i), i == 0, i == 3, 3'd0, 1'b0);
        idle(3);
        w = logged(0);
        chk("s1_n", log_q.size(), 1);
        chk("s1_sop", w[261], 1);
        chk("s1_eop", w[262], 1);
        chk("s1_err", w[263], 0);
        chk("s1_cnt", w[260:256], 31);
        chk("s1_payload", w[255:0], {pat(3), pat(2), pat(1), pat(0)});

        // 6-beat packet, rx_empty=5
        log_q.delete();
        for (int i = 0; i < 6; i++) send(pat(10 + i), i == 0, i == 5, 3'd5, 1'b0);
        idle(3);
        chk("s2_n", log_q.size(), 2);
        w = logged(0);
        chk("s2_w0_flags", w[266:256], {3'b000, 1'b0, 1'b0, 1'b1, 5'd31});
        w = logged(1);
        chk("s2_w1_flags", w[266:256], {3'b000, 1'b0, 1'b1, 1'b0, 5'd10});
        chk("s2_w1_upper", w[255:128], 0);
        chk("s2_w1_lower", w[127:0], {pat(15), pat(14)});

        // 1-beat packet, rx_empty=7
        log_q.delete();
        send(pat(20), 1'b1, 1'b1, 3'd7, 1'b0);
        idle(3);
        w = logged(0);
        chk("s3_n", log_q.size(), 1);
        chk("s3_word", w, {3'b000, 1'b0, 1'b1, 1'b1, 5'd0, 192'd0, pat(20)});

        // back-pressure: word held while FIFO full
        log_q.delete();
        ddpPktFull = 1'b1;
        send(pat(30), 1'b1, 1'b1, 3'd0, 1'b0);
        rx_data = pat(31); rx_sop = 1'b1; rx_eop = 1'b1; rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("s4_ready_low", rx_ready, 0);
            chk("s4_no_push", ddpPktPush, 0);
            chk("s4_stable", ddpPktDataIn, {3'b000, 1'b0, 1'b1, 1'b1, 5'd7, 192'd0, pat(30)});
            tick();
        end
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        ddpPktFull = 1'b0;
        @(negedge clock);
        chk("s4_push_after", ddpPktPush, 1);
        tick();
        idle(2);
        chk("s4_n", log_q.size(), 1);

        // error on beat 2, then clean packet
        log_q.delete();
        for (int i = 0; i < 4; i++) send(pat(40 + i), i == 0, i == 3, 3'd0, i == 2);
        for (int i = 0; i < 4; i++) send(pat(50 + i), i == 0, i == 3, 3'd0, 1'b0);
        idle(3);
        chk("s6_n", log_q.size(), 2);
        w = logged(0);
        chk("s6_err1", w[263], 1);
        w = logged(1);
        chk("s6_err2", w[263], 0);

        // drops then sop inside BODY
        reset = 1'b1;
        tick();
        reset = 1'b0;
        log_q.delete();
        for (int i = 0; i < 3; i++) send(pat(60 + i), 1'b0, 1'b0, 3'd0, 1'b0);
        send(pat(70), 1'b1, 1'b0, 3'd0, 1'b0);
        send(pat(71), 1'b0, 1'b0, 3'd0, 1'b0);
        send(pat(72), 1'b1, 1'b0, 3'd0, 1'b0);
        idle(3);
        chk("s5_drop", rxDropCnt, 4);
        chk("s5_n", log_q.size(), 1);
        w = logged(0);
        chk("s5_word", w, {3'b000, 1'b1, 1'b1, 1'b1, 5'd15, 128'd0, pat(71), pat(70)});

        // reset mid-packet and with a held word
        log_q.delete();
        send(pat(80), 1'b1, 1'b0, 3'd0, 1'b0);
        send(pat(81), 1'b0, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dz = pat(82);
        send(dz, 1'b1, 1'b1, 3'd0, 1'b0);
        idle(3);
        chk("s7_n", log_q.size(), 1);
        w = logged(0);
        chk("s7_word", w, {3'b000, 1'b0, 1'b1, 1'b1, 5'd7, 192'd0, dz});
        ddpPktFull = 1'b1;
        send(pat(83), 1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ddpPktFull = 1'b0;
        idle(3);
        chk("s7_no_push", log_q.size(), 1);
        chk("s7_drop", rxDropCnt, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = (c == 1500 || c == 1501);
            rx_valid   = ($urandom_range(9) < 7);
            rx_data    = {$urandom, $urandom};
            rx_sop     = ($urandom_range(4) == 0);
            rx_eop     = ($urandom_range(3) == 0);
            rx_empty   = 3'($urandom_range(7));
            rx_error   = ($urandom_range(15) == 0);
            ddpPktFull = ($urandom_range(3) == 0);
            tick();
        end
        reset = 1'b0;
        ddpPktFull = 1'b0;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
